// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the PRESENT nibble substitution datapath.
// Holds the forward/inverse S-box tables, the sequencer state type and the
// nibble width. Consumers: sbox_lut, substitution_seq.
package present_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Tables packed with entry 0 in bits [3:0], entry F in bits [63:60].
  // Forward: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX_FWD = 64'h21748FE3DA09B65C;
  // Inverse: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] sbox_lookup(input logic [63:0] tbl,
                                             input logic [3:0]  idx);
    return tbl[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sbox_lut.sv
// sbox_lut: single 4-bit PRESENT S-box, forward or inverse by i_inv.
module sbox_lut
  import present_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nib,
  input  logic                i_inv,
  output logic [NIBBLE_W-1:0] o_nib
);

  // Table lookup, inverse table selected when i_inv is set
  always_comb begin
    o_nib = i_inv ? sbox_lookup(SBOX_INV, i_nib) : sbox_lookup(SBOX_FWD, i_nib);
  end

endmodule

// File: rtl/substitution_seq.sv
// substitution_seq: multi-cycle PRESENT S-box layer over a WIDTH-bit state.
// LANES nibbles are substituted per cycle, low nibbles first, so a word takes
// WIDTH/(4*LANES) BUSY cycles. Valid/ready handshake on both sides.
// Optional feature: define SUBSTITUTION_INVERSE_EN to add inv_i, which selects
// the inverse S-box for the accepted word.
module substitution_seq
  import present_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
`ifdef SUBSTITUTION_INVERSE_EN
  input  logic             inv_i,
`endif
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned NNIB  = WIDTH / NIBBLE_W;
  localparam int unsigned NPASS = WIDTH / (NIBBLE_W * LANES);
  localparam int unsigned CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NPASS - 1);

  generate
    if (LANES < 1 || LANES > NNIB) begin : g_bad_lanes
      $error("substitution_seq: LANES must be in 1..WIDTH/4");
    end
    if (WIDTH % (NIBBLE_W * LANES) != 0) begin : g_bad_width
      $error("substitution_seq: WIDTH must be a multiple of 4*LANES");
    end
  endgenerate

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_data;
  logic                  r_out_valid;
  logic                  w_inv;
  logic                  w_accept;
  logic [WIDTH-1:0]      w_next;
  logic [NIBBLE_W-1:0]   w_lane_in  [LANES];
  logic [NIBBLE_W-1:0]   w_lane_out [LANES];

`ifdef SUBSTITUTION_INVERSE_EN
  logic r_inv;
  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  assign in_ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign out_valid_o = r_out_valid;
  assign data_o      = r_data;

  // Gather the nibbles of the current pass into the lane inputs
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane_in[l] = '0;
    end
    for (int unsigned k = 0; k < NNIB; k++) begin
      if (CW'(k / LANES) == r_cnt) begin
        w_lane_in[k % LANES] = r_data[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lut u_sbox (
      .i_nib (w_lane_in[l]),
      .i_inv (w_inv),
      .o_nib (w_lane_out[l])
    );
  end

  // Scatter substituted lanes back into the current pass, other nibbles held
  always_comb begin
    w_next = r_data;
    for (int unsigned k = 0; k < NNIB; k++) begin
      if (CW'(k / LANES) == r_cnt) begin
        w_next[k*NIBBLE_W +: NIBBLE_W] = w_lane_out[k % LANES];
      end
    end
  end

  // Sequencer: load, step passes, hold result until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
`ifdef SUBSTITUTION_INVERSE_EN
      r_inv       <= 1'b0;
`endif
    end else if (flush_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        // IDLE and DONE share the load path; w_accept already folds in
        // out_ready_i for DONE so a consumed result can chain a new word.
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_data      <= data_i;
            r_cnt       <= '0;
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b0;
`ifdef SUBSTITUTION_INVERSE_EN
            r_inv       <= inv_i;
`endif
          end else if ((r_state == ST_DONE) && out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_data <= w_next;
          if (r_cnt == LAST_CNT) begin
            r_cnt       <= '0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/substitution_seq.md
SUBSTITUTION_SEQ -- requirements
Module: substitution_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, state width in bits; multiple of 4*LANES.
REQ-002 SHALL have parameter LANES, default 4, S-boxes evaluated per cycle; 1..WIDTH/4.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  synchronous abort to IDLE.
REQ-006 SHALL have port in_valid_i  input  1  input word valid.
REQ-007 SHALL have port in_ready_o  output  1  block can accept input.
REQ-008 SHALL have port data_i  input  WIDTH  state to substitute.
REQ-009 SHALL have port out_valid_o  output  1  result valid.
REQ-010 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port data_o  output  WIDTH  substituted state.

Function
REQ-012 SHALL define N = WIDTH/(4*LANES) passes; counter width clog2(N), minimum 1.
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready_o in IDLE, and in DONE when out_ready_i=1 (back-to-back); otherwise 0.
REQ-015 SHALL, on in_valid_i && in_ready_o, load data_i into the state register, clear the counter, enter BUSY.
REQ-016 SHALL, each BUSY cycle, replace nibbles [cnt*LANES .. cnt*LANES+LANES-1] (nibble 0 = bits 3:0, low first) with S(nibble), other nibbles held, then increment cnt.
REQ-017 SHALL go BUSY->DONE on the edge processing cnt=N-1; out_valid_o high from the N-th edge after acceptance (latency N; N=1 gives one BUSY cycle).
REQ-018 SHALL hold data_o and out_valid_o stable in DONE until out_ready_i=1.
REQ-019 SHALL, in DONE with out_ready_i=1: go IDLE if in_valid_i=0, else load new data and go BUSY in the same edge.
REQ-020 SHALL ignore in_valid_i while BUSY (in_ready_o=0; no data loss because no acceptance).
REQ-021 SHALL make data_o the state register directly (intermediate values visible while BUSY; meaningful only when out_valid_o=1).
REQ-022 SHALL, on flush_i=1, go IDLE and clear the counter at the next edge, overriding all other events; state register contents unchanged.
REQ-023 SHALL use the PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (inputs 0..F).

Reset
REQ-024 SHALL, while rst=1, immediately force state IDLE, counter 0, state register 0, out_valid_o=0, in_ready_o=1 (data_o=0).
REQ-025 SHALL discard any in-flight operation on reset; no result emitted afterwards.

Configuration
REQ-026 SHALL support macro SUBSTITUTION_INVERSE_EN: when defined, add input inv_i (1 bit), sampled with the accepted word and held for the operation; inv_i=1 applies the inverse S-box 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-027 SHALL, without SUBSTITUTION_INVERSE_EN, have no inv_i port and forward S-box only.

Structure
REQ-028 SHALL place forward/inverse S-box tables, state enum type and nibble-width constant in shared package present_pkg.
REQ-029 SHALL instantiate LANES copies of sub-module sbox_lut (4-bit in, 4-bit out, inverse select tied 0 without the macro).
REQ-030 SHALL check WIDTH % (4*LANES) == 0 by elaboration-time assertion.

Verification
REQ-031 SHALL test defaults, data_i=64'h0 accepted -> out_valid_o on 4th edge, data_o=64'hCCCCCCCCCCCCCCCC.
REQ-032 SHALL test data_i=64'h0123456789ABCDEF with LANES=1,2,4,16 -> data_o=64'hC56B90AD3EF84712 after 16/8/4/1 cycles.
REQ-033 SHALL test out_ready_i low 5 cycles in DONE -> data_o and out_valid_o stable; in_ready_o=0 meanwhile.
REQ-034 SHALL test back-to-back: DONE with out_ready_i=1 and in_valid_i=1 (64'hFFFFFFFFFFFFFFFF) -> next result 64'h2222222222222222, no idle cycle.
REQ-035 SHALL test rst asserted mid-BUSY (cnt=2) -> out_valid_o=0, data_o=0 immediately; flush_i mid-BUSY -> IDLE next edge, no out_valid_o.
REQ-036 SHALL test with SUBSTITUTION_INVERSE_EN: 64'hC56B90AD3EF84712 with inv_i=1 -> 64'h0123456789ABCDEF.
